addsub_ovf_pipe: RTL and testbench
==================================

ADDSUB_OVF_PIPE -- requirements
Module: addsub_ovf_pipe

Interface
REQ-001 SHALL have parameter W, default 32, operand/result width (even, >=4).
REQ-002 SHALL have parameter CNT_W, default 8, width of the saturating overflow-event counter.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  operation offered.
REQ-006 SHALL have port in_ready  output  1  operation accepted when in_valid&&in_ready.
REQ-007 SHALL have port a, b  input  W each  operands.
REQ-008 SHALL have port sb  input  1  0 = a+b, 1 = a-b.
REQ-009 SHALL have port sgn  input  1  1 = signed overflow rule, 0 = unsigned rule.
REQ-010 SHALL have port out_valid  output  1  result held on outputs.
REQ-011 SHALL have port out_ready  input  1  consumer takes result when out_valid&&out_ready.
REQ-012 SHALL have port s  output  W  result, modulo 2^W.
REQ-013 SHALL have port c_out, of, zf, nf  output  1 each  carry-out, overflow, zero, negative flags of s.
REQ-014 SHALL have port of_sticky  output  1  latched overflow since last clear.
REQ-015 SHALL have port sticky_clr  input  1  clears of_sticky and of_cnt.
REQ-016 SHALL have port of_cnt  output  CNT_W  count of delivered results with of=1.

Function
REQ-017 SHALL compute s = a + (sb ? ~b : b) + sb; c_out = raw carry out of bit W-1.
REQ-018 SHALL split the add: stage 1 registers low W/2 bits, low carry, upper operand halves, sb, sgn; stage 2 completes upper half and all flags.
REQ-019 SHALL set of, when sgn=1, to (a[W-1]==beff[W-1]) && (s[W-1]!=a[W-1]), beff = sb ? ~b : b.
REQ-020 SHALL set of, when sgn=0, to c_out for add and !c_out (borrow) for subtract.
REQ-021 SHALL set zf = (s==0), nf = s[W-1] regardless of sgn.
REQ-022 SHALL give latency 2: accepted at edge N, out_valid=1 after edge N+1 when unstalled; throughput 1 op/cycle.
REQ-023 SHALL drive in_ready = !s1_valid || !out_valid || out_ready (stage 1 empty or able to advance), combinationally.
REQ-024 SHALL hold s and all flags stable while out_valid=1 and out_ready=0.
REQ-025 SHALL never drop, duplicate or reorder operations under any in_valid/out_ready pattern.
REQ-026 SHALL, when a result with of=1 is delivered (out_valid&&out_ready), set of_sticky and increment of_cnt, saturating at 2^CNT_W-1.
REQ-027 SHALL, on sticky_clr without simultaneous overflow delivery, clear of_sticky and of_cnt next edge.
REQ-028 SHALL, on sticky_clr coincident with overflow delivery, leave of_sticky=1 and of_cnt=1.
REQ-029 SHALL not update sticky/counter for results that are not yet delivered or are stalled.

Reset
REQ-030 SHALL, while rst=1 at an edge, clear both stage valids, of_sticky, of_cnt; out_valid=0 next cycle.
REQ-031 SHALL reset s, c_out, of, zf, nf to 0.
REQ-032 SHALL discard in-flight operations on reset mid-operation; no result delivered for them.
REQ-033 SHALL hold in_ready=0 during the cycle rst=1 is sampled, and 1 the first cycle after.
REQ-034 SHALL ignore in_valid, out_ready, sticky_clr while rst=1.

Verification
REQ-035 Signed add: a=0x7FFFFFFF, b=1, sb=0, sgn=1 -> 2 cycles later s=0x80000000, of=1, nf=1, c_out=0, of_sticky=1 after handshake, of_cnt=1.
REQ-036 Unsigned subtract: a=0, b=1, sb=1, sgn=0 -> s=0xFFFFFFFF, c_out=0, of=1; a=5, b=5, sb=1 -> s=0, zf=1, c_out=1, of=0.
REQ-037 Back-pressure: stream 4 ops with out_ready=0 for 3 cycles -> in_ready drops after 2 accepted, outputs stable, all 4 results delivered in order once out_ready=1.
REQ-038 Sticky: deliver overflow result with sticky_clr=1 same cycle -> of_sticky=1, of_cnt=1; next clr alone -> both 0; CNT_W=2 with 5 overflows -> of_cnt=3.
REQ-039 Reset mid-flight: 2 ops in pipe, assert rst one cycle -> out_valid=0, no result delivered, of_cnt=0; new op after reset delivers correctly.

Source files
------------

// File: rtl/addsub_ovf_pipe.sv
// Two-stage pipelined adder/subtractor with carry/overflow/zero/negative flags,
// valid/ready flow control and a sticky overflow flag with a saturating event counter.
module addsub_ovf_pipe #(
    parameter int unsigned W     = 32,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic             sb,
    input  logic             sgn,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     s,
    output logic             c_out,
    output logic             of,
    output logic             zf,
    output logic             nf,
    output logic             of_sticky,
    input  logic             sticky_clr,
    output logic [CNT_W-1:0] of_cnt
);

    localparam int unsigned H = W / 2;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic         s1_valid;
    logic [H-1:0] s1_lo;
    logic         s1_c;
    logic [H-1:0] s1_a_hi;
    logic [H-1:0] s1_b_hi;
    logic         s1_sb;
    logic         s1_sgn;

    logic [W-1:0] beff;
    logic [H:0]   lo_sum;
    logic [H:0]   hi_sum;
    logic         signed_of;
    logic         of_next;
    logic         accept;
    logic         s2_load;
    logic         deliver_of;

    // Handshake decode and the two half-width adders
    always_comb begin
        beff       = sb ? ~b : b;
        lo_sum     = {1'b0, a[H-1:0]} + {1'b0, beff[H-1:0]} + (H+1)'(sb);
        hi_sum     = {1'b0, s1_a_hi} + {1'b0, s1_b_hi} + (H+1)'(s1_c);
        signed_of  = (s1_a_hi[H-1] == s1_b_hi[H-1]) && (hi_sum[H-1] != s1_a_hi[H-1]);
        // Unsigned subtract overflows on borrow, i.e. when the carry is absent
        of_next    = s1_sgn ? signed_of : (hi_sum[H] ^ s1_sb);
        in_ready   = !rst && (!s1_valid || !out_valid || out_ready);
        accept     = in_valid && in_ready;
        s2_load    = s1_valid && (!out_valid || out_ready);
        deliver_of = out_valid && out_ready && of;
    end

    // Stage 1: low half sum plus upper operand halves
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else begin
            if (accept) begin
                s1_valid <= 1'b1;
                s1_lo    <= lo_sum[H-1:0];
                s1_c     <= lo_sum[H];
                s1_a_hi  <= a[W-1:H];
                s1_b_hi  <= beff[W-1:H];
                s1_sb    <= sb;
                s1_sgn   <= sgn;
            end else if (s2_load) begin
                s1_valid <= 1'b0;
            end
        end
    end

    // Stage 2: upper half and flags, held while the consumer stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            s         <= '0;
            c_out     <= 1'b0;
            of        <= 1'b0;
            zf        <= 1'b0;
            nf        <= 1'b0;
        end else begin
            if (s2_load) begin
                out_valid <= 1'b1;
                s         <= {hi_sum[H-1:0], s1_lo};
                c_out     <= hi_sum[H];
                of        <= of_next;
                zf        <= (hi_sum[H-1:0] == '0) && (s1_lo == '0);
                nf        <= hi_sum[H-1];
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Sticky flag and counter only see delivered results; a coincident clear keeps the new event
    always_ff @(posedge clk) begin
        if (rst) begin
            of_sticky <= 1'b0;
            of_cnt    <= '0;
        end else if (sticky_clr) begin
            of_sticky <= deliver_of;
            of_cnt    <= deliver_of ? CNT_W'(1) : '0;
        end else if (deliver_of) begin
            of_sticky <= 1'b1;
            if (of_cnt != CNT_MAX) begin
                of_cnt <= of_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_addsub_ovf_pipe.sv
// Self-checking bench for addsub_ovf_pipe: directed scenarios followed by random
// traffic, compared every cycle against an arithmetic reference model.
module tb_addsub_ovf_pipe;

    localparam int unsigned W     = 32;
    localparam int unsigned CNT_W = 2;
    localparam int          CNT_SAT = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic             sb;
    logic             sgn;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     s;
    logic             c_out;
    logic             of;
    logic             zf;
    logic             nf;
    logic             of_sticky;
    logic             sticky_clr;
    logic [CNT_W-1:0] of_cnt;

    always #5 clk = ~clk;

    addsub_ovf_pipe #(.W(W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .sb         (sb),
        .sgn        (sgn),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .s          (s),
        .c_out      (c_out),
        .of         (of),
        .zf         (zf),
        .nf         (nf),
        .of_sticky  (of_sticky),
        .sticky_clr (sticky_clr),
        .of_cnt     (of_cnt)
    );

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         of;
        logic         zf;
        logic         nf;
    } res_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    bit   m_s1_v;
    bit   m_out_v;
    res_t m_s1;
    res_t m_out;
    bit   m_sticky;
    int   m_cnt;
    bit   last_acc;

    // Expected result from plain integer arithmetic on the operands
    function automatic res_t ref_op(logic [W-1:0] x, logic [W-1:0] y, logic sub, logic sg);
        res_t   r;
        longint ux, uy, sx, sy, full, sr, lim;
        ux  = longint'(x);
        uy  = longint'(y);
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        lim = longint'(1) << (W - 1);
        if (sub) begin
            full = ux - uy;
            r.c  = (ux >= uy);
            sr   = sx - sy;
        end else begin
            full = ux + uy;
            r.c  = (full >= (longint'(1) << W));
            sr   = sx + sy;
        end
        r.s  = full[W-1:0];
        r.of = sg ? ((sr >= lim) || (sr < -lim)) : (sub ? !r.c : r.c);
        r.zf = (r.s == '0);
        r.nf = r.s[W-1];
        return r;
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Check outputs mid-cycle, then advance the model across the next rising edge
    task automatic tick();
        bit exp_rdy, acc, dlv, dof, adv;
        @(negedge clk);
        exp_rdy = !rst && (!m_s1_v || !m_out_v || out_ready);
        chk("in_ready", in_ready, exp_rdy);
        chk("out_valid", out_valid, m_out_v);
        if (m_out_v) begin
            chk("s", s, m_out.s);
            chk("c_out", c_out, m_out.c);
            chk("of", of, m_out.of);
            chk("zf", zf, m_out.zf);
            chk("nf", nf, m_out.nf);
        end
        chk("of_sticky", of_sticky, m_sticky);
        chk("of_cnt", of_cnt, m_cnt);
        if (rst) begin
            m_s1_v   = 0;
            m_out_v  = 0;
            m_sticky = 0;
            m_cnt    = 0;
            last_acc = 0;
        end else begin
            acc = in_valid && exp_rdy;
            dlv = m_out_v && out_ready;
            dof = dlv && m_out.of;
            adv = m_s1_v && (!m_out_v || out_ready);
            if (sticky_clr) begin
                m_sticky = dof;
                m_cnt    = dof ? 1 : 0;
            end else if (dof) begin
                m_sticky = 1;
                if (m_cnt < CNT_SAT) m_cnt++;
            end
            if (adv) begin
                m_out   = m_s1;
                m_out_v = 1;
            end else if (dlv) begin
                m_out_v = 0;
            end
            if (acc) begin
                m_s1   = ref_op(a, b, sb, sgn);
                m_s1_v = 1;
            end else if (adv) begin
                m_s1_v = 0;
            end
            last_acc = acc;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(logic [W-1:0] x, logic [W-1:0] y, logic sub, logic sg);
        a        = x;
        b        = y;
        sb       = sub;
        sgn      = sg;
        in_valid = 1'b1;
    endtask

    task automatic drain();
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        sticky_clr = 1'b0;
        for (int k = 0; k < 6; k++) tick();
        chk("drained", out_valid, 1'b0);
    endtask

    function automatic logic [W-1:0] rnd_opnd();
        logic [W-1:0] v;
        case ($urandom_range(0, 5))
            0:       v = '0;
            1:       v = '1;
            2:       v = {1'b0, {(W-1){1'b1}}};
            3:       v = {1'b1, {(W-1){1'b0}}};
            default: v = W'($urandom);
        endcase
        return v;
    endfunction

    initial begin
        logic [W-1:0] ops_a [4];
        logic [W-1:0] ops_b [4];
        int           idx;

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sb = 1'b0; sgn = 1'b0;
        out_ready = 1'b0; sticky_clr = 1'b0;
        m_s1_v = 0; m_out_v = 0; m_sticky = 0; m_cnt = 0; last_acc = 0;
        @(posedge clk);
        #1;
        tick();
        rst = 1'b0;
        chk("rst_s", s, '0);
        chk("rst_flags", {c_out, of, zf, nf}, 4'b0000);
        tick();

        // Signed overflow on add
        out_ready = 1'b1;
        set_op(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b1);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("sgn_ovf_sticky", of_sticky, 1'b1);
        chk("sgn_ovf_cnt", of_cnt, 1);

        // Unsigned borrow and exact-zero subtract
        set_op(32'h0, 32'h1, 1'b1, 1'b0);
        tick();
        set_op(32'h5, 32'h5, 1'b1, 1'b0);
        tick();
        in_valid = 1'b0;
        repeat (3) tick();

        // Back-pressure: four ops against a consumer stalled for three cycles
        for (int i = 0; i < 4; i++) begin
            ops_a[i] = W'($urandom);
            ops_b[i] = W'($urandom);
        end
        out_ready = 1'b0;
        idx = 0;
        for (int cyc = 0; cyc < 12 && idx < 4; cyc++) begin
            if (cyc == 3) out_ready = 1'b1;
            set_op(ops_a[idx], ops_b[idx], idx[0], idx[1]);
            tick();
            if (last_acc) idx++;
            if (cyc == 2) chk("bp_accepted", idx, 2);
        end
        drain();

        // Sticky clear racing an overflow delivery, then a lone clear
        sticky_clr = 1'b1;
        tick();
        sticky_clr = 1'b0;
        chk("clr_cnt", of_cnt, 0);
        out_ready = 1'b0;
        set_op(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b1);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        out_ready  = 1'b1;
        sticky_clr = 1'b1;
        tick();
        sticky_clr = 1'b0;
        chk("clr_coinc_sticky", of_sticky, 1'b1);
        chk("clr_coinc_cnt", of_cnt, 1);
        sticky_clr = 1'b1;
        tick();
        sticky_clr = 1'b0;
        chk("clr_alone_sticky", of_sticky, 1'b0);
        chk("clr_alone_cnt", of_cnt, 0);

        // Five overflows saturate the narrow counter
        for (int i = 0; i < 5; i++) begin
            if (i[0]) set_op(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
            else      set_op(32'h8000_0000, 32'h1, 1'b1, 1'b1);
            tick();
        end
        drain();
        chk("sat_cnt", of_cnt, CNT_SAT);

        // Reset with two operations in flight
        out_ready = 1'b0;
        set_op(32'h1234_5678, 32'h1, 1'b0, 1'b0);
        tick();
        set_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        tick();
        rst = 1'b1; out_ready = 1'b1; sticky_clr = 1'b1;
        tick();
        rst = 1'b0; in_valid = 1'b0; sticky_clr = 1'b0;
        chk("midrst_valid", out_valid, 1'b0);
        chk("midrst_cnt", of_cnt, 0);
        tick();
        tick();
        set_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
        tick();
        drain();

        // Random traffic with random stalls and occasional clears
        for (int i = 0; i < 400; i++) begin
            if (!in_valid || last_acc) begin
                set_op(rnd_opnd(), rnd_opnd(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                in_valid = ($urandom_range(0, 3) != 0);
            end
            out_ready  = ($urandom_range(0, 3) != 0);
            sticky_clr = ($urandom_range(0, 15) == 0);
            tick();
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
